dmem_arbiter: RTL

Data-memory arbiter and sequencer for the 16-bit pipelined processor. It shares one single-port data RAM between the MEM-stage load/store port and a debug/DMA port. For each request it computes the effective address (base + 6-bit constant), range-checks it, and runs the access through a three-state sequence. It raises a stall to the pipeline while a CPU access is outstanding.

---
 rtl/dmem_pkg.sv | 45 ++++
 rtl/dmem_array.sv | 47 ++++
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// dmem_pkg: opcodes, FSM/requester enums and data-RAM initial contents for dmem_arbiter.
package dmem_pkg;

  localparam logic [3:0] OPC_LW        = 4'd7;
  localparam logic [3:0] OPC_SW        = 4'd8;
  localparam int         DEPTH_DEFAULT = 31;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_t;

  function automatic logic [15:0] init_word(input int idx);
    logic [15:0] v;
    case (idx)
      0:       v = 16'd3;
      1:       v = 16'd5;
      2:       v = 16'd7;
      3:       v = 16'd1;
      4:       v = 16'd7;
      5:       v = 16'd2;
      6:       v = 16'd2;
      7:       v = 16'd4;
      8:       v = 16'd6;
      9:       v = 16'd1;
      10:      v = 16'd2;
      11:      v = 16'd8;
      12:      v = 16'd6;
      13:      v = 16'd5;
      14:      v = 16'd3;
      15:      v = 16'd2;
      default: v = 16'd2;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// dmem_array: synchronous single-port data RAM, DEPTH x 16, power-up contents from dmem_pkg.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] words [DEPTH];
  logic [15:0] rd_mux;

  // One register per word so each carries its own power-up value; never touched by reset.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [15:0] word_q = init_word(i);

    always_ff @(posedge clk) begin
      if (we && ({{(32-AW){1'b0}}, addr} == 32'(i))) begin
        word_q <= wdata;
      end
    end

    assign words[i] = word_q;
  end

  // Indices at or beyond DEPTH read back as zero.
  always_comb begin
    rd_mux = 16'h0000;
    for (int k = 0; k < DEPTH; k++) begin
      if ({{(32-AW){1'b0}}, addr} == 32'(k)) begin
        rd_mux = words[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    rdata <= rd_mux;
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// dmem_arbiter: round-robin CPU/DMA sharing of one data RAM through an IDLE/ACCESS/RESP sequence.
// Define DMEM_BOUNDS_CHECK_EN for full 16-bit range checking with err pulses.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_mem_read,
  input  logic        cpu_mem_write,
  input  logic [3:0]  cpu_opcode,
  input  logic [15:0] cpu_base,
  input  logic [5:0]  cpu_const,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_stall,
  output logic        cpu_err,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic [15:0] dma_rdata,
  output logic        dma_done,
  output logic        dma_err
);

  state_t      state;
  req_id_t     last_winner;
  req_id_t     win_id;
  logic [15:0] lat_addr;
  logic        lat_we;
  logic [15:0] lat_wdata;

  logic        cpu_valid;
  logic        cpu_we_req;
  logic [15:0] cpu_ea;
  logic        cpu_cand;
  logic        dma_cand;
  logic        grant_cpu;
  logic        in_range;
  logic        acc_err;
  logic        ram_we;
  logic [AW-1:0] ram_addr;
  logic [15:0] ram_rdata;
  logic [15:0] resp_data;

  assign cpu_valid  = (cpu_mem_read  && (cpu_opcode == OPC_LW)) ||
                      (cpu_mem_write && (cpu_opcode == OPC_SW));
  assign cpu_we_req = (cpu_opcode == OPC_SW);
  assign cpu_ea     = cpu_base + {10'b0, cpu_const};
  assign cpu_stall  = cpu_valid && !cpu_done;

  // A port's request is still held during its own done cycle; masking stops a re-issue.
  assign cpu_cand = cpu_valid && !cpu_done;
  assign dma_cand = dma_req && !dma_done;

  always_comb begin
    grant_cpu = cpu_cand;
    if (cpu_cand && dma_cand) begin
      grant_cpu = (last_winner == REQ_DMA);
    end
  end

`ifdef DMEM_BOUNDS_CHECK_EN
  assign in_range = ({16'b0, lat_addr} < 32'(DEPTH));
  assign acc_err  = !in_range;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^lat_addr[15:AW];
  assign in_range = ({{(32-AW){1'b0}}, lat_addr[AW-1:0]} < 32'(DEPTH));
  assign acc_err  = 1'b0;
`endif

  assign ram_addr  = lat_addr[AW-1:0];
  assign ram_we    = (state == ACCESS) && lat_we && in_range && !rst;
  assign resp_data = (in_range && !lat_we) ? ram_rdata : 16'h0000;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (lat_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_winner <= REQ_DMA;
      win_id      <= REQ_CPU;
      lat_addr    <= 16'h0000;
      lat_we      <= 1'b0;
      lat_wdata   <= 16'h0000;
      cpu_done    <= 1'b0;
      dma_done    <= 1'b0;
      cpu_err     <= 1'b0;
      dma_err     <= 1'b0;
      cpu_rdata   <= 16'h0000;
      dma_rdata   <= 16'h0000;
    end else begin
      cpu_done <= 1'b0;
      dma_done <= 1'b0;
      cpu_err  <= 1'b0;
      dma_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_cand || dma_cand) begin
            if (grant_cpu) begin
              win_id      <= REQ_CPU;
              last_winner <= REQ_CPU;
              lat_addr    <= cpu_ea;
              lat_we      <= cpu_we_req;
              lat_wdata   <= cpu_wdata;
            end else begin
              win_id      <= REQ_DMA;
              last_winner <= REQ_DMA;
              lat_addr    <= dma_addr;
              lat_we      <= dma_we;
              lat_wdata   <= dma_wdata;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          state <= RESP;
        end
        RESP: begin
          if (win_id == REQ_CPU) begin
            cpu_done  <= 1'b1;
            cpu_err   <= acc_err;
            cpu_rdata <= resp_data;
          end else begin
            dma_done  <= 1'b1;
            dma_err   <= acc_err;
            dma_rdata <= resp_data;
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
